// File: rtl/proc2_bus_responder_if.sv
// proc2 data-bus interface: the processor drives address, store data and the
// store strobe; the responder returns registered load data.
//   addr : word address
//   dout : store data
//   W    : store strobe (store committed at the rising edge while high)
//   DIN  : load data back to the processor
interface proc2_bus_responder_if;
  logic [15:0] addr;
  logic [15:0] dout;
  logic        W;
  logic [15:0] DIN;

  modport master (output addr, dout, W, input DIN);
  modport slave  (input addr, dout, W, output DIN);
endinterface

// File: rtl/proc2_bus_responder.sv
// Memory-mapped responder on the proc2 data bus. One-cycle fixed read latency
// so the processor never needs wait states.
// Address pages (addr[15:12]):
//   0x0 word RAM   0x1 LEDR   0x2 FIFO push (write-only)
//   0x3 switches (read-only)  0x4 FIFO status   others unmapped
// Ports:
//   Clock, Reset  : rising-edge clock, asynchronous active-high reset
//   bus           : proc2 bus (slave side)
//   SW            : asynchronous switch pins
//   LEDR          : LED register
//   out_data/out_valid/out_ready : FIFO drain port (valid/ready)
// Optional build macro BUS_ADDR_ERR_EN adds the sticky addr_err output,
// mirrored into status bit 14.
module proc2_bus_responder #(
  parameter int MEM_AW  = 7,
  parameter int FIFO_AW = 2,
  parameter int SW_W    = 10
) (
  input  logic                   Clock,
  input  logic                   Reset,
  proc2_bus_responder_if.slave   bus,
  input  logic [SW_W-1:0]        SW,
  output logic [15:0]            LEDR,
  output logic [15:0]            out_data,
  output logic                   out_valid,
  input  logic                   out_ready
`ifdef BUS_ADDR_ERR_EN
  ,
  output logic                   addr_err
`endif
);

  localparam int DEPTH = 2**FIFO_AW;

  logic [3:0]        page;
  logic [MEM_AW-1:0] ram_idx;
  assign page    = bus.addr[15:12];
  assign ram_idx = bus.addr[MEM_AW-1:0];

  // Upper in-page address bits alias onto the RAM index.
  logic unused_addr;
  assign unused_addr = ^bus.addr[11:MEM_AW];

  logic [15:0] mem      [2**MEM_AW];
  logic [15:0] fifo_mem [DEPTH];

  logic [15:0]        din_q, led_q;
  logic [SW_W-1:0]    sw_s1_q, sw_s2_q;
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic wr_ram, wr_led, wr_fifo, wr_stat;
  assign wr_ram  = bus.W && (page == 4'h0);
  assign wr_led  = bus.W && (page == 4'h1);
  assign wr_fifo = bus.W && (page == 4'h2);
  assign wr_stat = bus.W && (page == 4'h4);

  logic full, pop, push, ovf_set;
  assign full    = count_q[FIFO_AW];        // count never exceeds DEPTH
  assign pop     = out_valid && out_ready;
  assign push    = wr_fifo && (!full || pop);
  assign ovf_set = wr_fifo && full && !pop;

  assign out_valid = (count_q != '0);
  assign out_data  = fifo_mem[rd_ptr_q];
  assign LEDR      = led_q;
  assign bus.DIN   = din_q;

`ifdef BUS_ADDR_ERR_EN
  logic [15:0] addr_prev_q;
  logic        addr_err_q, addr_err_set;
  // Only count an unmapped access when it is a store or a new address, so a
  // parked bus does not keep re-flagging.
  assign addr_err_set = (page > 4'h4) && (bus.W || (bus.addr != addr_prev_q));
  assign addr_err     = addr_err_q;
`endif

  logic [15:0] status;
  always_comb begin
    status              = '0;
    status[FIFO_AW:0]   = count_q;
    status[15]          = ovf_q;
`ifdef BUS_ADDR_ERR_EN
    status[14]          = addr_err_q;
`endif
  end

  logic [15:0] rd_data;
  always_comb begin
    rd_data = '0;
    case (page)
      4'h0:    rd_data = mem[ram_idx];
      4'h1:    rd_data = led_q;
      4'h3:    rd_data = {{(16-SW_W){1'b0}}, sw_s2_q};
      4'h4:    rd_data = status;
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // Set beats clear when both land in the same cycle.
    ovf_d = ovf_set ? 1'b1 : (wr_stat ? 1'b0 : ovf_q);
  end

  // Storage arrays carry no reset; RAM read above sees the pre-edge value,
  // giving old-data read-during-write.
  always_ff @(posedge Clock) begin
    if (wr_ram) mem[ram_idx]       <= bus.dout;
    if (push)   fifo_mem[wr_ptr_q] <= bus.dout;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      din_q    <= '0;
      led_q    <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      din_q   <= rd_data;
      sw_s1_q <= SW;
      sw_s2_q <= sw_s1_q;
      if (wr_led) led_q    <= bus.dout;
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef BUS_ADDR_ERR_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      addr_prev_q <= '0;
      addr_err_q  <= 1'b0;
    end else begin
      addr_prev_q <= bus.addr;
      if (addr_err_set) addr_err_q <= 1'b1;
      else if (wr_stat) addr_err_q <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_proc2_bus_responder.sv
module tb_proc2_bus_responder;
  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [9:0]  SW = '0;
  logic [15:0] LEDR, out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
`ifdef BUS_ADDR_ERR_EN
  logic        addr_err;
`endif

  proc2_bus_responder_if bus();

  proc2_bus_responder dut (
    .Clock(Clock), .Reset(Reset), .bus(bus.slave), .SW(SW), .LEDR(LEDR),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef BUS_ADDR_ERR_EN
    , .addr_err(addr_err)
`endif
  );

  always #5 Clock = ~Clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural reference state
  logic [15:0] m_ram [128];
  logic [15:0] m_q [$];
  logic [15:0] m_led = '0, m_din = '0;
  logic        m_ovf = 1'b0;
  logic [9:0]  sw_h1 = '0, sw_h2 = '0;   // pin values sampled 1 and 2 edges ago

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    case (a[15:12])
      4'h0:    return m_ram[a[6:0]];
      4'h1:    return m_led;
      4'h3:    return {6'b0, sw_h2};
      4'h4:    return (16'(m_ovf) << 15) | 16'(m_q.size());
      default: return 16'h0000;
    endcase
  endfunction

  // One bus cycle: drive at negedge, advance the model across the edge,
  // then compare every observable output just after the edge.
  task automatic step(input bit w, input logic [15:0] a, input logic [15:0] d, input bit rdy);
    bit pop;
    @(negedge Clock);
    bus.W = w; bus.addr = a; bus.dout = d; out_ready = rdy;
    m_din = m_read(a);
    pop = (m_q.size() != 0) && rdy;
    if (pop) void'(m_q.pop_front());
    if (w) begin
      case (a[15:12])
        4'h0: m_ram[a[6:0]] = d;
        4'h1: m_led = d;
        4'h2: if (m_q.size() < DEPTH) m_q.push_back(d); else m_ovf = 1'b1;
        4'h4: m_ovf = 1'b0;
        default: ;
      endcase
    end
    sw_h2 = sw_h1;
    sw_h1 = SW;
    @(posedge Clock);
    #1;
    chk("DIN", bus.DIN, m_din);
    chk("LEDR", LEDR, m_led);
    chk("out_valid", {15'b0, out_valid}, {15'b0, m_q.size() != 0});
    if (m_q.size() != 0) chk("out_data", out_data, m_q[0]);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_led = '0; m_din = '0; m_ovf = 1'b0; sw_h1 = '0; sw_h2 = '0;
  endtask

  initial begin
    bus.W = 1'b0; bus.addr = '0; bus.dout = '0;
    #12;
    chk("rst_DIN", bus.DIN, 16'h0000);
    chk("rst_LEDR", LEDR, 16'h0000);
    chk("rst_valid", {15'b0, out_valid}, 16'h0000);
    @(negedge Clock); Reset = 1'b0;

    // Give every RAM word a known value.
    for (int i = 0; i < 128; i++) step(1'b1, 16'(i), 16'(i * 16'h0101) ^ 16'h5A5A, 1'b0);

    // RAM store/load and aliasing
    step(1'b1, 16'h0005, 16'hBEEF, 1'b0);
    step(1'b0, 16'h0005, 16'h0000, 1'b0);
    chk("ram_load", bus.DIN, 16'hBEEF);
    step(1'b0, 16'h0085, 16'h0000, 1'b0);
    chk("ram_alias", bus.DIN, 16'hBEEF);

    // Read-during-write returns old data
    step(1'b1, 16'h0003, 16'h1111, 1'b0);
    step(1'b1, 16'h0003, 16'h2222, 1'b0);
    chk("rdw_old", bus.DIN, 16'h1111);
    step(1'b0, 16'h0003, 16'h0000, 1'b0);
    chk("rdw_new", bus.DIN, 16'h2222);

    // LED and switch synchronizer latency
    step(1'b1, 16'h1000, 16'h00A5, 1'b0);
    chk("led", LEDR, 16'h00A5);
    SW = 10'h2AA;
    step(1'b0, 16'h3000, 16'h0000, 1'b0);
    step(1'b0, 16'h3000, 16'h0000, 1'b0);
    chk("sw_edge2", bus.DIN, 16'h0000);
    step(1'b0, 16'h3000, 16'h0000, 1'b0);
    chk("sw_edge3", bus.DIN, 16'h02AA);

    // FIFO fill, overflow, drain, status clear
    for (int i = 1; i <= 4; i++) step(1'b1, 16'h2000, 16'(i), 1'b0);
    step(1'b0, 16'h4000, 16'h0000, 1'b0);
    chk("stat_full", bus.DIN, 16'h0004);
    step(1'b1, 16'h2000, 16'h0005, 1'b0);
    step(1'b0, 16'h4000, 16'h0000, 1'b0);
    chk("stat_ovf", bus.DIN, 16'h8004);
    chk("head1", out_data, 16'h0001);
    for (int i = 2; i <= 4; i++) begin
      step(1'b0, 16'h0000, 16'h0000, 1'b1);
      chk("drain", out_data, 16'(i));
    end
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("drained", {15'b0, out_valid}, 16'h0000);
    step(1'b1, 16'h4000, 16'h1234, 1'b0);
    step(1'b0, 16'h4000, 16'h0000, 1'b0);
    chk("stat_clr", bus.DIN, 16'h0000);

    // Push and pop together while full
    for (int i = 1; i <= 4; i++) step(1'b1, 16'h2000, 16'h0010 + 16'(i), 1'b0);
    step(1'b1, 16'h2000, 16'h0009, 1'b1);
    step(1'b0, 16'h4000, 16'h0000, 1'b0);
    chk("stat_pp", bus.DIN, 16'h0004);
    chk("pp_head", out_data, 16'h0012);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("pp_last", out_data, 16'h0009);
    step(1'b0, 16'h0000, 16'h0000, 1'b1);
    chk("pp_empty", {15'b0, out_valid}, 16'h0000);

    // Async reset mid-operation
    for (int i = 0; i < 3; i++) step(1'b1, 16'h2000, 16'h00A0 + 16'(i), 1'b0);
    step(1'b1, 16'h1000, 16'hFFFF, 1'b0);
    step(1'b0, 16'h1000, 16'h0000, 1'b0);
    chk("pre_rst_DIN", bus.DIN, 16'hFFFF);
    #2 Reset = 1'b1;
    #1;
    model_reset();
    chk("arst_LEDR", LEDR, 16'h0000);
    chk("arst_valid", {15'b0, out_valid}, 16'h0000);
    chk("arst_DIN", bus.DIN, 16'h0000);
    @(negedge Clock); Reset = 1'b0;
    step(1'b0, 16'h4000, 16'h0000, 1'b0);
    chk("arst_stat", bus.DIN, 16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      logic [3:0] pg;
      if ($urandom_range(0, 9) == 0) SW = 10'($urandom);
      pg = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(5, 15)) : 4'($urandom_range(0, 4));
      step(1'($urandom_range(0, 1)), {pg, 12'($urandom)}, 16'($urandom),
           $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/proc2_bus_responder.md
Name: proc2_bus_responder

Overview:
- Memory-mapped responder on the proc2 data-bus interface (addr, dout, W in; DIN out).
- Services processor loads and stores with fixed one-cycle read latency, so proc2 timing needs no wait states.
- Contains:
  - word RAM;
  - LED output register;
  - synchronized switch input;
  - output FIFO with valid/ready drain port and status register.

Parameters:
MEM_AW, 7, RAM address width; RAM holds 2**MEM_AW 16-bit words
FIFO_AW, 2, FIFO address width; FIFO depth = 2**FIFO_AW entries
SW_W, 10, switch input width

Ports:
Clock  input  1  single system clock, rising edge
Reset  input  1  asynchronous, active-high reset
addr  input  16  word address from processor
dout  input  16  store data from processor
W  input  1  store strobe; store committed at rising edge while 1
DIN  output  16  load data to processor, registered
SW  input  SW_W  asynchronous switch inputs
LEDR  output  16  LED register
out_data  output  16  FIFO head word
out_valid  output  1  FIFO non-empty
out_ready  input  1  consumer accepts head word this cycle

Behaviour:
- Decode on addr[15:12]:
  - 0x0: RAM, index addr[MEM_AW-1:0].
  - 0x1: LEDR.
  - 0x2: FIFO data (write-only; reads return 0).
  - 0x3: SW (read-only).
  - 0x4: FIFO status.
  - All others: unmapped; reads return 0, writes ignored.
- Reset asserted (async):
  - DIN=0, LEDR=0, FIFO count=0, out_valid=0, overflow=0, SW sync stages=0.
  - RAM contents are not reset.
  - Reset mid-transfer discards all FIFO contents.
- Read:
  - DIN at edge N+1 reflects the mapped location addressed in cycle N.
  - DIN is updated every cycle regardless of W.
- Read-during-write, same RAM word: DIN returns the OLD value; the new value is visible on the next read.
- Write, W=1 at edge:
  - RAM[idx]<=dout.
  - LEDR<=dout.
  - FIFO push of dout.
  - Status write: any value clears overflow.
  - SW writes ignored.
- SW: two-flop synchronizer. Read value = sync stage 2 zero-extended to 16 bits; latency 2 edges from pin change.
- FIFO:
  - Circular buffer, wr/rd pointers wrap modulo depth; count 0..depth.
  - out_data = head entry (combinational from storage); undefined content when empty but out_valid=0.
  - pop when out_valid & out_ready.
  - push when FIFO-data write AND (not full OR pop same cycle).
  - Push while full and no pop: data dropped, overflow<=1 (sticky).
  - Push+pop same cycle: count unchanged, order preserved.
  - Empty with push: out_valid rises next edge; no same-cycle bypass.
- Status read value: bit15=overflow, bits[FIFO_AW:0]=count, other bits 0.
- Overflow set and clear in the same cycle: set wins.

Optional Feature:
- Macro BUS_ADDR_ERR_EN.
- Defined:
  - Extra output addr_err (1 bit, reset 0).
  - Sticky-set at the edge of any access (read every cycle counts; qualify by W or by a decoded unmapped page only when W=1 or when addr changes from the previous cycle) to an unmapped page.
  - Cleared only by Reset or by a write to status (same as overflow).
  - Status bit14 mirrors addr_err.
- Undefined: no addr_err port; status bit14 reads 0; unmapped accesses silently ignored.

Test Plan:
- RAM store/load: W=1, addr=0x0005, dout=0xBEEF. Next cycle W=0, addr=0x0005 -> DIN=0xBEEF one edge later. addr=0x0085 (aliases idx 5 with MEM_AW=7) -> DIN=0xBEEF.
- Read-during-write: RAM[3]=0x1111, then W=1, addr=0x0003, dout=0x2222 -> DIN=0x1111 after that edge; next read -> 0x2222.
- LED/SW:
  - Write 0x00A5 to 0x1000 -> LEDR=0x00A5.
  - SW=0x2AA -> read 0x3000 returns 0x02AA no earlier than the 3rd edge after the change.
- FIFO fill/overflow (depth 4), out_ready=0:
  - Push 1,2,3,4 -> status=0x0004.
  - Push 5 -> status=0x8004, 5 dropped.
  - out_ready=1 drains 1,2,3,4 in order, then out_valid=0.
  - Write status -> reads 0x0000.
- Simultaneous push/pop when full: push 0x0009 while out_ready=1 -> count stays 4; the drained sequence ends with 0x0009; overflow stays 0.
- Async reset mid-operation: FIFO holding 3 words, LEDR=0xFFFF, assert Reset between edges -> immediately LEDR=0, out_valid=0, DIN=0; after release, status reads 0x0000.
